fifo_push_arb: RTL and testbench
================================

FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter NREQ, default 4, number of producers sharing one fifo push port (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, producer and fifo data width.
REQ-003 Parameter BURST_MAX, default 4, maximum accepted pushes per grant (1..15).
REQ-004 clk  input  1  single clock, all state changes on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NREQ  per-producer push request, level, held until released by producer.
REQ-007 req_data  input  NREQ*DATA_WIDTH  producer data, slice i belongs to req[i].
REQ-008 ack  output  NREQ  one-hot pulse, beat of producer i accepted this cycle.
REQ-009 gnt  output  NREQ  one-hot current owner, all zero in IDLE.
REQ-010 fifo_full  input  1  full flag of the downstream fifo.
REQ-011 fifo_push  output  1  push strobe to fifo.
REQ-012 fifo_data_in  output  DATA_WIDTH  data to fifo.
REQ-013 stat_sel  input  3  producer index for statistics readout.
REQ-014 stat_cnt  output  8  statistics value for producer stat_sel.

Function
REQ-015 FSM states IDLE and BURST; registers owner, rr_ptr (next-priority index), beat_cnt (4 bits).
REQ-016 IDLE: if any req bit set and fifo_full=0, owner <= first set req index searching from rr_ptr upward with wrap, beat_cnt <= 0, go BURST; otherwise stay IDLE.
REQ-017 No push in the IDLE cycle; first beat earliest one cycle after req rises (arbitration latency 1).
REQ-018 BURST: fifo_push = req[owner] & ~fifo_full, combinational; fifo_data_in = req_data slice owner at all times in BURST, zero in IDLE.
REQ-019 ack[owner] = fifo_push; all other ack bits 0; gnt = one-hot owner in BURST.
REQ-020 Each accepted beat increments beat_cnt.
REQ-021 BURST->IDLE when an accepted beat has beat_cnt = BURST_MAX-1, or when req[owner]=0; rr_ptr <= (owner+1) mod NREQ on exit.
REQ-022 fifo_full=1 in BURST: stall, no push, no ack, ownership and beat_cnt held; release by req[owner]=0 still honoured.
REQ-023 Requests from non-owners never preempt the owner; each producer wins within NREQ grants of raising req (no starvation).
REQ-024 Changes on req of non-owners during BURST have no effect until the next IDLE cycle.

Reset
REQ-025 rst_n=0 at posedge clk: state IDLE, owner 0, rr_ptr 0, beat_cnt 0, statistics counters 0; fifo_push, ack, gnt, fifo_data_in, stat_cnt all 0.
REQ-026 Reset mid-burst aborts the burst with no push in the reset cycle; the next grant after release starts from producer 0.

Configuration
REQ-027 Macro FIFO_PUSH_ARB_STATS_EN, when defined: per-producer 8-bit accepted-beat counters, increment on each ack, saturate at 255, stat_cnt = counter[stat_sel] combinationally; stat_sel >= NREQ reads 0.
REQ-028 Without FIFO_PUSH_ARB_STATS_EN: no counters built, stat_cnt tied 0, stat_sel ignored, all other behaviour identical.

Verification
REQ-029 req=4'b0001 held, fifo_full=0, data 0xA0.. -> grant after 1 cycle, 4 pushes, IDLE 1 cycle, regrant, beats continue.
REQ-030 req=4'b1111 held, rr_ptr 0 -> bursts owned in order 0,1,2,3,0, each exactly 4 beats with correct slice data.
REQ-031 Owner 2 mid-burst after 2 beats, fifo_full=1 for 3 cycles -> no push/ack for 3 cycles, gnt stays 4'b0100, remaining 2 beats after full drops.
REQ-032 Owner 1 drops req after 1 beat, req[3]=1 -> IDLE next cycle, then owner 3, rr_ptr 2 before the IDLE cycle.
REQ-033 rst_n=0 for 1 cycle during burst of owner 3 -> all outputs 0 that cycle, next grant goes to lowest set req from index 0.
REQ-034 STATS_EN, 300 beats from producer 0 -> stat_sel=0 reads 255, stat_sel=5 reads 0; without macro stat_cnt always 0.

Source files
------------

// File: rtl/fifo_push_arb.sv
// -----------------------------------------------------------------------------
// fifo_push_arb
//   Round-robin arbiter that lets NREQ producers share a single fifo push port.
//   A winner owns the port for a burst of up to BURST_MAX accepted beats.
//   Ownership ends early when the owner drops its request. Full-fifo cycles
//   stall the burst without losing ownership.
//
// Parameters
//   NREQ       number of producers (2..8)
//   DATA_WIDTH producer / fifo data width
//   BURST_MAX  maximum accepted beats per grant (1..15)
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_req[NREQ]      level push request per producer
//   i_req_data       producer data, slice i belongs to i_req[i]
//   o_ack[NREQ]      one-hot pulse, beat of the owner accepted this cycle
//   o_gnt[NREQ]      one-hot current owner, zero while idle
//   i_fifo_full      downstream fifo full flag
//   o_fifo_push      push strobe to the fifo
//   o_fifo_data_in   data to the fifo (owner's slice during a burst, else 0)
//   i_stat_sel       producer index for statistics readout
//   o_stat_cnt       accepted-beat count of producer i_stat_sel
//   o_dbg_state      FSM state (0 = IDLE, 1 = BURST)
//
// Handshake: a beat transfers in a cycle where the owner holds i_req high and
// i_fifo_full is low; o_fifo_push and o_ack[owner] assert in that same cycle.
//
// Build option
//   FIFO_PUSH_ARB_STATS_EN  when defined, builds saturating 8-bit per-producer
//                           accepted-beat counters readable via i_stat_sel.
//                           When undefined, o_stat_cnt is tied to zero.
// -----------------------------------------------------------------------------
module fifo_push_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req,
  input  logic [NREQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]            o_ack,
  output logic [NREQ-1:0]            o_gnt,
  input  logic                       i_fifo_full,
  output logic                       o_fifo_push,
  output logic [DATA_WIDTH-1:0]      o_fifo_data_in,
  input  logic [2:0]                 i_stat_sel,
  output logic [7:0]                 o_stat_cnt,
  output logic                       o_dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr_ptr;
  logic [3:0]      r_beat_cnt;

  logic            w_any_req;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic            w_owner_req;
  logic            w_in_burst;
  logic            w_push;
  logic            w_last_beat;
  logic [IW-1:0]   w_next_rr;
  logic [NREQ-1:0] w_owner_oh;

  // Round-robin pick: first set request starting at r_rr_ptr, wrapping at NREQ.
  // The sum is one bit wider so the wrap also works for non power-of-two NREQ.
  always_comb begin
    logic [SW-1:0] sum;
    logic [IW-1:0] cand;
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, r_rr_ptr} + SW'(i);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      cand = sum[IW-1:0];
      if (!w_found && i_req[cand]) begin
        w_found = 1'b1;
        w_pick  = cand;
      end
    end
  end

  assign w_any_req   = |i_req;
  assign w_owner_req = i_req[r_owner];
  // Outputs are forced low during a reset cycle so an aborted burst never pushes.
  assign w_in_burst  = i_rst_n && (r_state == ST_BURST);
  assign w_push      = w_in_burst && w_owner_req && !i_fifo_full;
  assign w_last_beat = (r_beat_cnt == 4'(BURST_MAX - 1));
  assign w_next_rr   = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
  assign w_owner_oh  = NREQ'(1) << r_owner;

  assign o_fifo_push    = w_push;
  assign o_ack          = w_push ? w_owner_oh : '0;
  assign o_gnt          = w_in_burst ? w_owner_oh : '0;
  assign o_fifo_data_in = w_in_burst ? i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_dbg_state    = (r_state == ST_BURST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req && !i_fifo_full) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Exit either on the final allowed beat or when the owner lets go;
          // a stall (fifo full) holds everything unless the owner releases.
          if (!w_owner_req || (w_push && w_last_beat)) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= w_next_rr;
            r_beat_cnt <= '0;
          end else if (w_push) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [7:0] r_stat [NREQ];
  logic [7:0] w_stat_rd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        r_stat[i] <= '0;
      end
    end else if (w_push && (r_stat[r_owner] != 8'hFF)) begin
      r_stat[r_owner] <= r_stat[r_owner] + 8'd1;
    end
  end

  // Out-of-range selects fall through the loop and read zero.
  always_comb begin
    w_stat_rd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_stat_sel == 3'(i)) begin
        w_stat_rd = r_stat[i];
      end
    end
  end

  assign o_stat_cnt = i_rst_n ? w_stat_rd : '0;
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^i_stat_sel;
  assign o_stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
module tb_fifo_push_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int W  = N + DW;

`ifdef FIFO_PUSH_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_push;
  logic [DW-1:0]   fifo_data_in;
  logic [2:0]      stat_sel;
  logic [7:0]      stat_cnt;
  logic            dbg_state;

  fifo_push_arb #(.NREQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_req_data     (req_data),
    .o_ack          (ack),
    .o_gnt          (gnt),
    .i_fifo_full    (fifo_full),
    .o_fifo_push    (fifo_push),
    .o_fifo_data_in (fifo_data_in),
    .i_stat_sel     (stat_sel),
    .o_stat_cnt     (stat_cnt),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    stat_sel  = '0;
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          push;
    logic [DW-1:0] data;
    logic [7:0]    stat;
  } cyc_t;

  logic [W-1:0] exp_q[$];   // accepted beats: {ack, data}
  cyc_t         cyc_q[$];   // per-cycle expected outputs

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, where the search starts next time,
  // how many beats the current burst has delivered, and beat counts per producer.
  int m_owner = -1;
  int m_next  = 0;
  int m_beats = 0;
  int m_stat[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    cyc_t e;
    e = '0;
    if (!rst_n) begin
      m_owner = -1;
      m_next  = 0;
      m_beats = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else begin
      if (STATS && (int'(stat_sel) < N)) e.stat = 8'(m_stat[stat_sel]);
      if (m_owner < 0) begin
        if (req != '0 && !fifo_full) begin
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_next + k) % N;
            if (req[i]) begin
              m_owner = i;
              m_beats = 0;
              break;
            end
          end
        end
      end else begin
        e.gnt  = N'(1) << m_owner;
        e.data = req_data[m_owner*DW +: DW];
        if (req[m_owner] && !fifo_full) begin
          e.push = 1'b1;
          e.ack  = e.gnt;
          exp_q.push_back({e.ack, e.data});
          m_beats++;
          if (m_stat[m_owner] < 255) m_stat[m_owner]++;
        end
        if (!req[m_owner] || (e.push && m_beats == BM)) begin
          m_next  = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
    cyc_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [N-1:0] rq, input logic full,
                       input logic [N*DW-1:0] d, input logic [2:0] sel);
    @(posedge clk);
    #1;
    rst_n     = r;
    req       = rq;
    fifo_full = full;
    req_data  = d;
    stat_sel  = sel;
    model_step();
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    return {$urandom};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("gnt",       32'(gnt),          32'(e.gnt));
      check("ack",       32'(ack),          32'(e.ack));
      check("fifo_push", 32'(fifo_push),    32'(e.push));
      check("data_in",   32'(fifo_data_in), 32'(e.data));
      check("stat_cnt",  32'(stat_cnt),     32'(e.stat));
      if (fifo_push) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 32'(fifo_push), 32'd0);
        end else begin
          logic [W-1:0] b;
          b = exp_q.pop_front();
          check("beat", 32'({ack, fifo_data_in}), 32'(b));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] rq;

    // reset state
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    drive(1'b0, '0, 1'b0, '0, 3'd0);

    // single producer held: grant, 4 beats, 1 idle, regrant
    for (int k = 0; k < 12; k++)
      drive(1'b1, 4'b0001, 1'b0, {24'h0, 8'(8'hA0 + k)}, 3'd0);

    // all producers held: bursts in order 0,1,2,3,0
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    for (int k = 0; k < 26; k++)
      drive(1'b1, 4'b1111, 1'b0,
            {8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 8'(k)}, 3'(k % 4));

    // owner 2 stalls 3 cycles after 2 beats
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    for (int k = 0; k < 10; k++)
      drive(1'b1, 4'b0100, (k >= 3 && k <= 5), rand_data(), 3'd2);

    // owner 1 releases after 1 beat while producer 3 requests
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    for (int k = 0; k < 9; k++)
      drive(1'b1, (k < 2) ? 4'b0010 : 4'b1000, 1'b0, rand_data(), 3'd1);

    // reset in the middle of owner 3's burst
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    for (int k = 0; k < 3; k++)
      drive(1'b1, 4'b1000, 1'b0, rand_data(), 3'd3);
    drive(1'b0, 4'b1010, 1'b0, rand_data(), 3'd3);
    for (int k = 0; k < 6; k++)
      drive(1'b1, 4'b1010, 1'b0, rand_data(), 3'd1);

    // long run on producer 0 to reach counter saturation
    drive(1'b0, '0, 1'b0, '0, 3'd0);
    for (int k = 0; k < 400; k++)
      drive(1'b1, 4'b0001, 1'b0, rand_data(), (k % 2 == 0) ? 3'd0 : 3'd5);

    // randomized traffic with stalls and occasional resets
    rq = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      drive(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 3) == 0),
            rand_data(), 3'($urandom_range(0, 7)));
    end

    drive(1'b1, '0, 1'b0, '0, 3'd0);
    drive(1'b1, '0, 1'b0, '0, 3'd0);
    @(negedge clk);
    #1;
    check("beats_outstanding",  32'(exp_q.size()), 32'd0);
    check("cycles_outstanding", 32'(cyc_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
